// File: rtl/pipe_hazard_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared constants and types for the pipeline hazard/sequencer block.
//   REG_W      : register-file address width used by the core
//   WORD_WIDTH : datapath word width of the core
//   state_t    : memory-wait sequencer states (RUN / MEM_WAIT)
// ----------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

   localparam int REG_W      = 4;
   localparam int WORD_WIDTH = 32;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl_hazard_detect
// Pure combinational RAW-hazard comparator between the ID source registers
// and the EXE / MEM destination registers.
//   FWD_EN=1 : forwarding exists, so only a load in EXE can hazard.
//   FWD_EN=0 : any writing instruction in EXE or MEM hazards.
// Ports:
//   id_src1/2, id_src1/2_vld          ID operands and their use flags
//   exe_dest, exe_wb_en, exe_mem_r_en EXE destination, writeback, load flag
//   mem_dest, mem_wb_en               MEM destination, writeback flag
//   hazard                            stall request for the ID instruction
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl_hazard_detect #(
   parameter bit FWD_EN = 1'b1,
   parameter int REG_W  = pipe_hazard_ctrl_pkg::REG_W
) (
   input  logic [REG_W-1:0] id_src1,
   input  logic [REG_W-1:0] id_src2,
   input  logic             id_src1_vld,
   input  logic             id_src2_vld,
   input  logic [REG_W-1:0] exe_dest,
   input  logic             exe_wb_en,
   input  logic             exe_mem_r_en,
   input  logic [REG_W-1:0] mem_dest,
   input  logic             mem_wb_en,
   output logic             hazard
);

   logic exe_hit;
   logic mem_hit;

   assign exe_hit = exe_wb_en & ((id_src1_vld & (id_src1 == exe_dest)) |
                                 (id_src2_vld & (id_src2 == exe_dest)));
   assign mem_hit = mem_wb_en & ((id_src1_vld & (id_src1 == mem_dest)) |
                                 (id_src2_vld & (id_src2 == mem_dest)));

   // With forwarding, only a load result is unavailable in time for ID.
   assign hazard = FWD_EN ? (exe_hit & exe_mem_r_en) : (exe_hit | mem_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central sequencer for the 5-stage core: freeze/flush of IF, bubbles into
// ID/EXE, global freeze while data memory is busy, memory-wait watchdog and
// saturating performance counters.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   id_*, exe_*, mem_dest/wb_en    hazard comparator inputs
//   branch_taken                   branch resolved taken in EXE
//   mem_req, mem_ready             MEM-stage access handshake
//   perf_clr                       synchronous clear of counters and mem_err
//   if_freeze, if_flush, id_flush  front-end controls
//   global_freeze                  hold all stage registers and PC
//   mem_err                        sticky memory-timeout flag
//   stall_cnt, flush_cnt,
//   memwait_cnt                    saturating event counters
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter bit FWD_EN      = 1'b1,
   parameter int REG_W       = pipe_hazard_ctrl_pkg::REG_W,
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] id_src1,
   input  logic [REG_W-1:0] id_src2,
   input  logic             id_src1_vld,
   input  logic             id_src2_vld,
   input  logic [REG_W-1:0] exe_dest,
   input  logic             exe_wb_en,
   input  logic             exe_mem_r_en,
   input  logic [REG_W-1:0] mem_dest,
   input  logic             mem_wb_en,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   input  logic             perf_clr,
   output logic             if_freeze,
   output logic             if_flush,
   output logic             id_flush,
   output logic             global_freeze,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] memwait_cnt
);

   localparam int          WAIT_W    = $clog2(MEM_TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   state_t            state_reg, state_next;
   logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
   logic              mem_err_reg;
   logic              err_set;

   logic hazard;
   logic mem_stall;
   logic timeout_hit;
   logic freeze_raw;
   logic br_act;
   logic stall_act;

   pipe_hazard_ctrl_hazard_detect #(
      .FWD_EN (FWD_EN),
      .REG_W  (REG_W)
   ) u_hazard_detect (
      .id_src1      (id_src1),
      .id_src2      (id_src2),
      .id_src1_vld  (id_src1_vld),
      .id_src2_vld  (id_src2_vld),
      .exe_dest     (exe_dest),
      .exe_wb_en    (exe_wb_en),
      .exe_mem_r_en (exe_mem_r_en),
      .mem_dest     (mem_dest),
      .mem_wb_en    (mem_wb_en),
      .hazard       (hazard)
   );

   // ------------------------------------------------------------------
   // Memory-wait sequencer. wait_cnt counts wait cycles already spent,
   // including the RUN cycle in which the wait began, so the freeze is
   // released on the MEM_TIMEOUT-th consecutive wait cycle.
   // ------------------------------------------------------------------
   assign mem_stall   = mem_req & ~mem_ready;
   assign timeout_hit = (state_reg == MEM_WAIT) && (wait_cnt_reg == WAIT_LAST);
   assign freeze_raw  = mem_stall & ~timeout_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= RUN;
         wait_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      wait_cnt_next = wait_cnt_reg;
      err_set       = 1'b0;
      case (state_reg)
         RUN: begin
            if (mem_stall) begin
               state_next    = MEM_WAIT;
               wait_cnt_next = WAIT_W'(1);
            end else begin
               wait_cnt_next = '0;
            end
         end
         MEM_WAIT: begin
            if (mem_ready || timeout_hit) begin
               state_next    = RUN;
               wait_cnt_next = '0;
               // A completion in the same cycle as the deadline is not an error.
               err_set       = timeout_hit & ~mem_ready;
            end else begin
               wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
            end
         end
         default: begin
            state_next    = RUN;
            wait_cnt_next = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Control priority: freeze > branch flush > data-hazard stall.
   // Outputs are forced low while rst is asserted so nothing leaks out
   // of a reset taken in the middle of a memory wait.
   // ------------------------------------------------------------------
   assign br_act    = ~rst & ~freeze_raw & branch_taken;
   assign stall_act = ~rst & ~freeze_raw & ~branch_taken & hazard;

   assign global_freeze = ~rst & freeze_raw;
   assign if_flush      = br_act;
   assign if_freeze     = stall_act;
   assign id_flush      = br_act | stall_act;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_err_reg <= 1'b0;
      end else if (perf_clr) begin
         mem_err_reg <= 1'b0;
      end else if (err_set) begin
         mem_err_reg <= 1'b1;
      end
   end

   assign mem_err = mem_err_reg;

   // ------------------------------------------------------------------
   // Saturating event counters: 0 = stall, 1 = flush, 2 = memory wait.
   // ------------------------------------------------------------------
   logic [2:0]       cnt_inc;
   logic [CNT_W-1:0] cnt_reg [3];

   assign cnt_inc = {global_freeze, br_act, stall_act};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt_reg[gi] <= '0;
            end else if (perf_clr) begin
               cnt_reg[gi] <= '0;
            end else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
               cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
            end
         end
      end
   endgenerate

   assign stall_cnt   = cnt_reg[0];
   assign flush_cnt   = cnt_reg[1];
   assign memwait_cnt = cnt_reg[2];

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Two instances share one stimulus stream: u_fwd (FWD_EN=1, 16-bit counters)
// and u_nofwd (FWD_EN=0, 4-bit counters so saturation is reachable). Both use
// MEM_TIMEOUT=8. Expected controls are queued when a cycle is driven and
// popped when that cycle's outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
   logic       id_src1_vld, id_src2_vld, exe_wb_en, exe_mem_r_en, mem_wb_en;
   logic       branch_taken, mem_req, mem_ready, perf_clr;

   logic        f_if_freeze, f_if_flush, f_id_flush, f_gfreeze, f_mem_err;
   logic [15:0] f_stall, f_flush, f_wait;
   logic        n_if_freeze, n_if_flush, n_id_flush, n_gfreeze, n_mem_err;
   logic [3:0]  n_stall, n_flush, n_wait;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.FWD_EN(1'b1), .REG_W(4), .CNT_W(16), .MEM_TIMEOUT(8)) u_fwd (
      .clk(clk), .rst(rst),
      .id_src1(id_src1), .id_src2(id_src2),
      .id_src1_vld(id_src1_vld), .id_src2_vld(id_src2_vld),
      .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
      .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
      .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
      .perf_clr(perf_clr),
      .if_freeze(f_if_freeze), .if_flush(f_if_flush), .id_flush(f_id_flush),
      .global_freeze(f_gfreeze), .mem_err(f_mem_err),
      .stall_cnt(f_stall), .flush_cnt(f_flush), .memwait_cnt(f_wait)
   );

   pipe_hazard_ctrl #(.FWD_EN(1'b0), .REG_W(4), .CNT_W(4), .MEM_TIMEOUT(8)) u_nofwd (
      .clk(clk), .rst(rst),
      .id_src1(id_src1), .id_src2(id_src2),
      .id_src1_vld(id_src1_vld), .id_src2_vld(id_src2_vld),
      .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
      .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
      .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
      .perf_clr(perf_clr),
      .if_freeze(n_if_freeze), .if_flush(n_if_flush), .id_flush(n_id_flush),
      .global_freeze(n_gfreeze), .mem_err(n_mem_err),
      .stall_cnt(n_stall), .flush_cnt(n_flush), .memwait_cnt(n_wait)
   );

   // Control nibble: {if_freeze, if_flush, id_flush, global_freeze}
   logic [3:0] ctl_f, ctl_n;
   assign ctl_f = {f_if_freeze, f_if_flush, f_id_flush, f_gfreeze};
   assign ctl_n = {n_if_freeze, n_if_flush, n_id_flush, n_gfreeze};

   typedef struct {
      logic [3:0] src1; logic [3:0] src2; logic v1; logic v2;
      logic [3:0] ed; logic ewb; logic eld;
      logic [3:0] md; logic mwb;
      logic br; logic req; logic rdy;
      logic [3:0] exp_f; logic [3:0] exp_n;
   } vec_t;

   typedef struct {
      logic [3:0] exp_f; logic [3:0] exp_n; logic clr; string name;
   } exp_t;

   exp_t sb_q[$];
   vec_t tbl[12];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Unsaturated event counts; saturation is applied at compare time.
   int m_stall_f = 0, m_flush_f = 0, m_wait_f = 0;
   int m_stall_n = 0, m_flush_n = 0, m_wait_n = 0;

   function automatic int sat(input int x, input int m);
      return (x > m) ? m : x;
   endfunction

   task automatic cmp(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic zero_model();
      m_stall_f = 0; m_flush_f = 0; m_wait_f = 0;
      m_stall_n = 0; m_flush_n = 0; m_wait_n = 0;
   endtask

   task automatic apply(input vec_t v, input logic clr, input string nm);
      exp_t e;
      id_src1 = v.src1; id_src2 = v.src2; id_src1_vld = v.v1; id_src2_vld = v.v2;
      exe_dest = v.ed; exe_wb_en = v.ewb; exe_mem_r_en = v.eld;
      mem_dest = v.md; mem_wb_en = v.mwb;
      branch_taken = v.br; mem_req = v.req; mem_ready = v.rdy; perf_clr = clr;
      e.exp_f = v.exp_f; e.exp_n = v.exp_n; e.clr = clr; e.name = nm;
      sb_q.push_back(e);
   endtask

   // Samples the current cycle on the falling edge, then advances to just
   // after the next rising edge (where counter updates are visible).
   task automatic settle();
      exp_t e;
      @(negedge clk);
      if (sb_q.size() == 0) begin
         n_cmp++; n_bad++;
         $display("FAIL scoreboard: got empty queue expected an entry");
      end else begin
         e = sb_q.pop_front();
         $display("txn %-12s ctl_fwd=%b (exp %b) ctl_nofwd=%b (exp %b)",
                  e.name, ctl_f, e.exp_f, ctl_n, e.exp_n);
         cmp({e.name, "_ctl_fwd"}, int'(ctl_f), int'(e.exp_f));
         cmp({e.name, "_ctl_nofwd"}, int'(ctl_n), int'(e.exp_n));
         if (e.clr) begin
            zero_model();
         end else begin
            m_stall_f += int'(e.exp_f[3]); m_flush_f += int'(e.exp_f[2]);
            m_wait_f  += int'(e.exp_f[0]);
            m_stall_n += int'(e.exp_n[3]); m_flush_n += int'(e.exp_n[2]);
            m_wait_n  += int'(e.exp_n[0]);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cycle(input vec_t v, input logic clr, input string nm);
      apply(v, clr, nm);
      settle();
   endtask

   task automatic chk_cnt(input string nm);
      cmp({nm, "_stall_fwd"},   int'(f_stall), sat(m_stall_f, 65535));
      cmp({nm, "_flush_fwd"},   int'(f_flush), sat(m_flush_f, 65535));
      cmp({nm, "_wait_fwd"},    int'(f_wait),  sat(m_wait_f, 65535));
      cmp({nm, "_stall_nofwd"}, int'(n_stall), sat(m_stall_n, 15));
      cmp({nm, "_flush_nofwd"}, int'(n_flush), sat(m_flush_n, 15));
      cmp({nm, "_wait_nofwd"},  int'(n_wait),  sat(m_wait_n, 15));
   endtask

   task automatic chk_err(input string nm, input logic exp);
      cmp({nm, "_err_fwd"},   int'(f_mem_err), int'(exp));
      cmp({nm, "_err_nofwd"}, int'(n_mem_err), int'(exp));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t idle, lu, memw, memrdy, brw, brrdy;
      //         src1 src2 v1 v2 ed ewb eld md mwb br req rdy exp_f    exp_n
      idle   = '{0,  0,  0, 0, 0, 0, 0,  0, 0,  0, 0, 0, 4'b0000, 4'b0000};
      lu     = '{3,  0,  1, 0, 3, 1, 1,  0, 0,  0, 0, 0, 4'b1010, 4'b1010};
      memw   = '{0,  0,  0, 0, 0, 0, 0,  0, 0,  0, 1, 0, 4'b0001, 4'b0001};
      memrdy = '{0,  0,  0, 0, 0, 0, 0,  0, 0,  0, 1, 1, 4'b0000, 4'b0000};
      brw    = '{0,  0,  0, 0, 0, 0, 0,  0, 0,  1, 1, 0, 4'b0001, 4'b0001};
      brrdy  = '{0,  0,  0, 0, 0, 0, 0,  0, 0,  1, 1, 1, 4'b0110, 4'b0110};

      tbl[0]  = idle;
      tbl[1]  = lu;                                                        // load-use
      tbl[2]  = '{3,  0,  1, 0, 3, 1, 1,  0, 0,  1, 0, 0, 4'b0110, 4'b0110}; // branch beats hazard
      tbl[3]  = '{0,  5,  0, 1, 9, 0, 0,  5, 1,  0, 0, 0, 4'b0000, 4'b1010}; // MEM match
      tbl[4]  = '{7,  0,  1, 0, 7, 1, 0,  0, 0,  0, 0, 0, 4'b0000, 4'b1010}; // EXE ALU match
      tbl[5]  = '{3,  3,  0, 0, 3, 1, 1,  3, 1,  0, 0, 0, 4'b0000, 4'b0000}; // sources unused
      tbl[6]  = '{3,  0,  1, 0, 3, 0, 1,  0, 0,  0, 0, 0, 4'b0000, 4'b0000}; // no writeback
      tbl[7]  = '{0, 15,  0, 1,15, 1, 1,  0, 0,  0, 0, 0, 4'b1010, 4'b1010}; // r15 as dest
      tbl[8]  = memrdy;                                                    // access done at once
      tbl[9]  = '{0,  0,  0, 0, 0, 0, 0,  0, 0,  1, 0, 0, 4'b0110, 4'b0110}; // plain branch
      tbl[10] = '{4,  0,  1, 0, 3, 1, 1,  0, 0,  0, 0, 0, 4'b0000, 4'b0000}; // reg mismatch
      tbl[11] = '{2,  6,  1, 1, 6, 1, 1,  2, 1,  0, 0, 0, 4'b1010, 4'b1010}; // src2 load-use

      // Reset with a pending memory stall and hazard on the inputs.
      rst = 1'b1;
      apply(lu, 1'b0, "rst_hold");
      void'(sb_q.pop_back());
      mem_req = 1'b1; mem_ready = 1'b0;
      #2;
      cmp("rst_ctl_fwd", int'(ctl_f), 0);
      cmp("rst_ctl_nofwd", int'(ctl_n), 0);
      chk_cnt("rst");
      chk_err("rst", 1'b0);
      @(posedge clk); #1;
      apply(idle, 1'b0, "rst_rel");
      void'(sb_q.pop_back());
      @(posedge clk); #1;
      rst = 1'b0;

      // Table-driven single-cycle vectors.
      for (int i = 0; i < 12; i++) begin
         cycle(tbl[i], 1'b0, $sformatf("tbl%0d", i));
      end
      chk_cnt("tbl");

      // Memory wait of 5 cycles with a branch held across it.
      for (int i = 0; i < 5; i++) cycle(brw, 1'b0, $sformatf("wait%0d", i));
      cycle(brrdy, 1'b0, "wait_rel");
      cycle(idle, 1'b0, "wait_idle");
      chk_cnt("wait");
      chk_err("wait", 1'b0);

      // Timeout: freeze for 7 cycles, released on the 8th.
      for (int i = 0; i < 7; i++) cycle(memw, 1'b0, $sformatf("to%0d", i));
      chk_err("to_pre", 1'b0);
      apply(memw, 1'b0, "to_hit");
      sb_q[sb_q.size()-1].exp_f = 4'b0000;
      sb_q[sb_q.size()-1].exp_n = 4'b0000;
      settle();
      chk_err("to_hit", 1'b1);
      for (int i = 0; i < 3; i++) cycle(idle, 1'b0, $sformatf("to_idle%0d", i));
      chk_err("to_sticky", 1'b1);
      chk_cnt("to");

      // Clear beats a simultaneous stall increment.
      cycle(lu, 1'b1, "clr");
      chk_cnt("clr");
      chk_err("clr", 1'b0);

      // Saturation of the 4-bit counter in u_nofwd.
      for (int i = 0; i < 20; i++) cycle(lu, 1'b0, $sformatf("sat%0d", i));
      chk_cnt("sat");

      // Asynchronous reset in the middle of a memory wait.
      for (int i = 0; i < 3; i++) cycle(memw, 1'b0, $sformatf("mw%0d", i));
      apply(memw, 1'b0, "mw_rst");
      void'(sb_q.pop_back());
      #2;
      rst = 1'b1;
      #1;
      cmp("arst_ctl_fwd", int'(ctl_f), 0);
      cmp("arst_ctl_nofwd", int'(ctl_n), 0);
      zero_model();
      chk_cnt("arst");
      chk_err("arst", 1'b0);
      @(posedge clk); #1;
      apply(idle, 1'b0, "arst_rel");
      void'(sb_q.pop_back());
      rst = 1'b0;
      cycle(idle, 1'b0, "post_rst");
      cycle(memrdy, 1'b0, "post_mem");
      cycle(memw, 1'b0, "post_w0");
      cycle(memrdy, 1'b0, "post_w1");
      chk_cnt("post");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
